mcif_rr_arb5_ctrl: RTL and testbench

- Sequential round-robin arbiter/sequencer that shares the single MCIF memory-command port among 5 requesters.
- Selects the next client round-robin relative to the last granted id, issues one command with valid/ready handshake, then holds the grant until the burst's data beats complete.
- Sits between client request logic and the MCIF command/data path.

---
 rtl/mcif_rr_arb5_pkg.sv | 17 +
 rtl/mcif_rr_arb5_pick.sv | 30 +++
 rtl/mcif_rr_arb5_ctrl.sv | 155 +++++++++++++++
 tb/tb_mcif_rr_arb5_ctrl.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcif_rr_arb5_pkg.sv
// Shared constants and types for the 5-client MCIF round-robin arbiter.
package mcif_rr_arb5_pkg;

    localparam int unsigned NumClients = 5;
    localparam int unsigned IdW        = 3;

    // After reset the last granted id is the highest one, so client 0 wins first.
    localparam logic [IdW-1:0] LastIdRst = 3'd4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StArb  = 2'd1,
        StCmd  = 2'd2,
        StXfer = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mcif_rr_arb5_pick.sv
// Combinational rotate-priority picker: first requester after last_id, wrapping 4->0,
// ending at last_id itself. A corrupted last_id (5..7) is treated as 4.
module mcif_rr_pick5
    import mcif_rr_arb5_pkg::*;
(
    input  logic [IdW-1:0]        last_id,
    input  logic [NumClients-1:0] req,
    output logic [IdW-1:0]        nxt_id
);

    logic [IdW-1:0] base;
    logic [IdW-1:0] idx;
    logic           found;

    // Scan the clients in rotated order starting just after the last grant.
    always_comb begin
        base   = (last_id >= IdW'(NumClients)) ? IdW'(NumClients - 1) : last_id;
        nxt_id = base;
        idx    = base;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NumClients; k++) begin
            idx = IdW'((32'(base) + k) % NumClients);
            if (!found && req[idx]) begin
                nxt_id = idx;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mcif_rr_arb5_ctrl.sv
// Round-robin arbiter/sequencer sharing the MCIF command port among 5 clients.
// Optional watchdog enabled by defining MCIF_ARB_WDOG_EN; without it wdog_err is 0
// and the FSM waits indefinitely for cmd_rdy / beat_vld.
module mcif_rr_arb5_ctrl
    import mcif_rr_arb5_pkg::*;
#(
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned WDOG_CYC = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NumClients-1:0]       arb_req,
    input  logic [NumClients*LEN_W-1:0] arb_len,
    input  logic                        cmd_rdy,
    input  logic                        beat_vld,
    output logic                        cmd_vld,
    output logic [IdW-1:0]              cmd_id,
    output logic [LEN_W-1:0]            cmd_len,
    output logic [NumClients-1:0]       arb_gnt,
    output logic                        arb_busy,
    output logic                        wdog_err
);

    arb_state_e       state;
    logic [IdW-1:0]   last_id;
    logic [IdW-1:0]   nxt_id;
    logic [LEN_W-1:0] beat_cnt;
    logic [LEN_W-1:0] len_arr [NumClients];

    mcif_rr_pick5 u_pick (
        .last_id (last_id),
        .req     (arb_req),
        .nxt_id  (nxt_id)
    );

    // Unpack the flat per-client length bus so it can be indexed by client id.
    always_comb begin
        for (int unsigned i = 0; i < NumClients; i++) begin
            len_arr[i] = arb_len[i*LEN_W +: LEN_W];
        end
    end

`ifdef MCIF_ARB_WDOG_EN
    localparam int unsigned WdogW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;

    logic [WdogW-1:0] wdog_cnt;
    logic             wdog_fire;

    // Fires on the stalled cycle that would bring the idle count up to WDOG_CYC.
    always_comb begin
        wdog_fire = 1'b0;
        if ((state == StCmd && !cmd_rdy) || (state == StXfer && !beat_vld)) begin
            wdog_fire = (wdog_cnt == WdogW'(WDOG_CYC - 1));
        end
    end

    // Idle-cycle counter: cleared on CMD entry and on any progress, sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b0;
        end else if (state == StArb) begin
            wdog_cnt <= '0;
        end else if ((state == StCmd && cmd_rdy) || (state == StXfer && beat_vld)) begin
            wdog_cnt <= '0;
        end else if (state == StCmd || state == StXfer) begin
            if (wdog_fire) begin
                wdog_cnt <= '0;
                wdog_err <= 1'b1;
            end else begin
                wdog_cnt <= wdog_cnt + WdogW'(1);
            end
        end
    end
`else
    logic wdog_fire;

    // No watchdog: never fires. The parameter is referenced so it is consumed in both builds.
    assign wdog_fire = 1'b0 & (WDOG_CYC != 0);
    assign wdog_err  = 1'b0;
`endif

    // Main FSM with registered outputs; a watchdog timeout overrides the normal transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= StIdle;
            last_id  <= LastIdRst;
            beat_cnt <= '0;
            cmd_vld  <= 1'b0;
            cmd_id   <= '0;
            cmd_len  <= '0;
            arb_gnt  <= '0;
            arb_busy <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (|arb_req) begin
                        state    <= StArb;
                        arb_busy <= 1'b1;
                    end
                end
                StArb: begin
                    if (|arb_req) begin
                        cmd_id   <= nxt_id;
                        cmd_len  <= len_arr[nxt_id];
                        arb_gnt  <= NumClients'(1) << nxt_id;
                        last_id  <= nxt_id;
                        cmd_vld  <= 1'b1;
                        state    <= StCmd;
                    end else begin
                        // Requests vanished: no grant, last_id keeps its value.
                        state    <= StIdle;
                        arb_busy <= 1'b0;
                    end
                end
                StCmd: begin
                    if (cmd_rdy) begin
                        cmd_vld  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= StXfer;
                    end
                end
                StXfer: begin
                    if (beat_vld) begin
                        if (beat_cnt == cmd_len) begin
                            arb_gnt <= '0;
                            if (|arb_req) begin
                                state <= StArb;
                            end else begin
                                state    <= StIdle;
                                arb_busy <= 1'b0;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + LEN_W'(1);
                        end
                    end
                end
                default: begin
                    state    <= StIdle;
                    cmd_vld  <= 1'b0;
                    arb_gnt  <= '0;
                    arb_busy <= 1'b0;
                end
            endcase

            if (wdog_fire) begin
                state    <= StIdle;
                cmd_vld  <= 1'b0;
                arb_gnt  <= '0;
                arb_busy <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mcif_rr_arb5_ctrl.sv
// Self-checking bench for mcif_rr_arb5_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level round-robin model.
module tb_mcif_rr_arb5_ctrl;

    localparam int LW = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  arb_req = '0;
    logic [19:0] arb_len = '0;
    logic        cmd_rdy = 1'b0;
    logic        beat_vld = 1'b0;
    logic        cmd_vld;
    logic [2:0]  cmd_id;
    logic [3:0]  cmd_len;
    logic [4:0]  arb_gnt;
    logic        arb_busy;
    logic        wdog_err;

    int checks = 0;
    int errors = 0;

    mcif_rr_arb5_ctrl #(
        .LEN_W    (LW),
        .WDOG_CYC (64)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .arb_req  (arb_req),
        .arb_len  (arb_len),
        .cmd_rdy  (cmd_rdy),
        .beat_vld (beat_vld),
        .cmd_vld  (cmd_vld),
        .cmd_id   (cmd_id),
        .cmd_len  (cmd_len),
        .arb_gnt  (arb_gnt),
        .arb_busy (arb_busy),
        .wdog_err (wdog_err)
    );

    always #5 clk = ~clk;

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arb_req  = '0;
        arb_len  = '0;
        cmd_rdy  = 1'b0;
        beat_vld = 1'b0;
        rst_n    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_cmd(input int limit, output bit ok);
        int n = 0;
        while (cmd_vld !== 1'b1 && n < limit) begin
            step();
            n++;
        end
        ok = (cmd_vld === 1'b1);
    endtask

    // Accept the pending command and deliver len+1 back-to-back beats.
    task automatic finish_txn(input int len);
        cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        for (int b = 0; b <= len; b++) begin
            beat_vld = 1'b1;
            step();
        end
        beat_vld = 1'b0;
    endtask

    // Reference: among pending clients, the one at smallest rotational distance after last.
    function automatic int model_pick(input int last, input logic [4:0] req);
        int best = -1;
        int best_d = 99;
        for (int i = 0; i < 5; i++) begin
            if (req[i]) begin
                int d = (i - last - 1 + 10) % 5;
                if (d < best_d) begin
                    best_d = d;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if ({cmd_vld, cmd_id, cmd_len, arb_gnt, arb_busy, wdog_err} !== 15'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want all zero",
                     {cmd_vld, cmd_id, cmd_len, arb_gnt, arb_busy, wdog_err});
        end
        beat_vld = 1'b1;
        step();
        step();
        beat_vld = 1'b0;
        checks++;
        if (arb_busy !== 1'b0 || arb_gnt !== 5'b0) begin
            errors++;
            $display("FAIL idle_beat_ignored busy=%b gnt=%b want 0/0", arb_busy, arb_gnt);
        end
    endtask

    task automatic test_single_client();
        do_reset();
        arb_len[3:0] = 4'd3;
        arb_req = 5'b00001;
        cmd_rdy = 1'b1;
        step();
        checks++;
        if (arb_busy !== 1'b1 || cmd_vld !== 1'b0) begin
            errors++;
            $display("FAIL single_arb busy=%b vld=%b want 1/0", arb_busy, cmd_vld);
        end
        step();
        checks++;
        if (cmd_vld !== 1'b1 || cmd_id !== 3'd0 || arb_gnt !== 5'b00001 || cmd_len !== 4'd3) begin
            errors++;
            $display("FAIL single_cmd vld=%b id=%0d gnt=%b len=%0d want 1/0/00001/3",
                     cmd_vld, cmd_id, arb_gnt, cmd_len);
        end
        arb_req = 5'b0;
        step();
        cmd_rdy = 1'b0;
        checks++;
        if (cmd_vld !== 1'b0 || arb_gnt !== 5'b00001) begin
            errors++;
            $display("FAIL single_xfer vld=%b gnt=%b want 0/00001", cmd_vld, arb_gnt);
        end
        for (int b = 0; b < 4; b++) begin
            beat_vld = 1'b1;
            step();
            checks++;
            if (b < 3 && arb_gnt !== 5'b00001) begin
                errors++;
                $display("FAIL single_gnt_held beat=%0d gnt=%b want 00001", b, arb_gnt);
            end else if (b == 3 && (arb_gnt !== 5'b0 || arb_busy !== 1'b0)) begin
                errors++;
                $display("FAIL single_done gnt=%b busy=%b want 0/0", arb_gnt, arb_busy);
            end
        end
        beat_vld = 1'b0;
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        arb_req  = 5'b11111;
        cmd_rdy  = 1'b1;
        beat_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_cmd(10, ok);
            checks++;
            if (!ok || cmd_id !== 3'(k % 5)) begin
                errors++;
                $display("FAIL fair_order idx=%0d vld=%b id=%0d want %0d", k, cmd_vld, cmd_id, k % 5);
            end
            step();
        end
        arb_req  = '0;
        cmd_rdy  = 1'b0;
        beat_vld = 1'b0;
        step();
        step();
    endtask

    task automatic run_txn(input logic [4:0] req, input bit hold, input int exp_id);
        bit ok;
        arb_req = req;
        wait_cmd(10, ok);
        checks++;
        if (!ok || cmd_id !== 3'(exp_id) || arb_gnt !== (5'b1 << exp_id)) begin
            errors++;
            $display("FAIL rr_pick req=%b vld=%b id=%0d gnt=%b want id %0d", req, cmd_vld,
                     cmd_id, arb_gnt, exp_id);
        end
        if (!hold) arb_req = '0;
        finish_txn(0);
    endtask

    task automatic test_last_id();
        do_reset();
        run_txn(5'b00100, 1'b0, 2);
        run_txn(5'b00011, 1'b1, 0);
        run_txn(5'b00011, 1'b0, 1);
        step();
        step();
    endtask

    task automatic test_cmd_stall();
        bit ok;
        do_reset();
        arb_len[11:8] = 4'd5;
        arb_req = 5'b00100;
        wait_cmd(10, ok);
        arb_req = '0;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (!ok || cmd_vld !== 1'b1 || cmd_id !== 3'd2 || cmd_len !== 4'd5) begin
                errors++;
                $display("FAIL stall_stable cyc=%0d vld=%b id=%0d len=%0d want 1/2/5", c, cmd_vld,
                         cmd_id, cmd_len);
            end
        end
`ifndef MCIF_ARB_WDOG_EN
        repeat (70) step();
        checks++;
        if (cmd_vld !== 1'b1 || arb_gnt !== 5'b00100 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL no_wdog_wait vld=%b gnt=%b err=%b want 1/00100/0", cmd_vld, arb_gnt,
                     wdog_err);
        end
`endif
        cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        checks++;
        if (cmd_vld !== 1'b0 || arb_gnt !== 5'b00100) begin
            errors++;
            $display("FAIL stall_to_xfer vld=%b gnt=%b want 0/00100", cmd_vld, arb_gnt);
        end
        beat_vld = 1'b1;
        repeat (6) step();
        beat_vld = 1'b0;
        checks++;
        if (arb_gnt !== 5'b0 || arb_busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_done gnt=%b busy=%b want 0/0", arb_gnt, arb_busy);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        do_reset();
        arb_len[3:0] = 4'd3;
        arb_req = 5'b00001;
        wait_cmd(10, ok);
        arb_req = '0;
        cmd_rdy = 1'b1;
        step();
        cmd_rdy  = 1'b0;
        beat_vld = 1'b1;
        step();
        step();
        beat_vld = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || {cmd_vld, cmd_id, cmd_len, arb_gnt, arb_busy, wdog_err} !== 15'b0) begin
            errors++;
            $display("FAIL async_reset got %b want all zero",
                     {cmd_vld, cmd_id, cmd_len, arb_gnt, arb_busy, wdog_err});
        end
        step();
        rst_n = 1'b1;
        step();
        arb_req = 5'b01000;
        step();
        checks++;
        if (cmd_vld !== 1'b0 || arb_busy !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_arb vld=%b busy=%b want 0/1", cmd_vld, arb_busy);
        end
        step();
        checks++;
        if (cmd_vld !== 1'b1 || cmd_id !== 3'd3 || arb_gnt !== 5'b01000) begin
            errors++;
            $display("FAIL post_reset_grant vld=%b id=%0d gnt=%b want 1/3/01000", cmd_vld, cmd_id,
                     arb_gnt);
        end
        arb_req = '0;
        finish_txn(0);
    endtask

    task automatic test_random();
        bit          ok;
        int          last = 4;
        int          exp_id;
        int          exp_len;
        logic [4:0]  pend;
        logic [19:0] lens;
        do_reset();
        pend = 5'($urandom_range(1, 31));
        lens = 20'($urandom);
        arb_req = pend;
        arb_len = lens;
        wait_cmd(10, ok);
        for (int t = 0; t < 40; t++) begin
            exp_id  = model_pick(last, pend);
            exp_len = int'(lens[exp_id*4 +: 4]);
            checks++;
            if (cmd_vld !== 1'b1 || cmd_id !== 3'(exp_id) || cmd_len !== 4'(exp_len) ||
                arb_gnt !== (5'b1 << exp_id)) begin
                errors++;
                $display("FAIL rand_grant txn=%0d vld=%b id=%0d len=%0d gnt=%b want 1/%0d/%0d",
                         t, cmd_vld, cmd_id, cmd_len, arb_gnt, exp_id, exp_len);
            end
            last = exp_id;
            if ($urandom_range(0, 3) != 0) pend[exp_id] = 1'b0;
            pend = pend | (5'($urandom) & 5'($urandom));
            if (pend == 5'b0) pend[$urandom_range(0, 4)] = 1'b1;
            lens    = 20'($urandom);
            arb_req = pend;
            arb_len = lens;
            repeat ($urandom_range(0, 2)) begin
                step();
                checks++;
                if (cmd_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_cmd_hold txn=%0d vld=%b want 1", t, cmd_vld);
                end
            end
            cmd_rdy = 1'b1;
            step();
            cmd_rdy = 1'b0;
            for (int b = 0; b <= exp_len; b++) begin
                repeat ($urandom_range(0, 2)) step();
                beat_vld = 1'b1;
                step();
                beat_vld = 1'b0;
                checks++;
                if (b < exp_len && arb_gnt !== (5'b1 << exp_id)) begin
                    errors++;
                    $display("FAIL rand_gnt_held txn=%0d beat=%0d gnt=%b", t, b, arb_gnt);
                end else if (b == exp_len && arb_gnt !== 5'b0) begin
                    errors++;
                    $display("FAIL rand_gnt_clear txn=%0d gnt=%b want 0", t, arb_gnt);
                end
            end
            step();
            step();
            checks++;
            if (cmd_vld !== 1'b1) begin
                errors++;
                $display("FAIL rand_b2b_latency txn=%0d vld=%b want 1", t, cmd_vld);
            end
        end
        arb_req = '0;
        finish_txn(0);
    endtask

`ifdef MCIF_ARB_WDOG_EN
    task automatic test_watchdog();
        bit ok;
        int n = 0;
        do_reset();
        arb_req = 5'b00010;
        wait_cmd(10, ok);
        arb_req = '0;
        cmd_rdy = 1'b1;
        step();
        cmd_rdy = 1'b0;
        while (arb_gnt !== 5'b0 && n < 200) begin
            step();
            n++;
        end
        checks++;
        if (!ok || n != 64 || wdog_err !== 1'b1 || arb_busy !== 1'b0 || cmd_vld !== 1'b0) begin
            errors++;
            $display("FAIL wdog_fire cycles=%0d err=%b busy=%b want 64/1/0", n, wdog_err, arb_busy);
        end
        arb_req = 5'b00001;
        wait_cmd(10, ok);
        arb_req = '0;
        finish_txn(0);
        checks++;
        if (wdog_err !== 1'b1) begin
            errors++;
            $display("FAIL wdog_sticky err=%b want 1", wdog_err);
        end
        do_reset();
        checks++;
        if (wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL wdog_reset err=%b want 0", wdog_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_client();
        test_fairness();
        test_last_id();
        test_cmd_stall();
        test_reset_mid();
        test_random();
`ifdef MCIF_ARB_WDOG_EN
        test_watchdog();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
